// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator machine.
// Holds PC, IR, MBR and AC, drives main memory, and feeds the downstream ALU.
module control_sequencer #(
    parameter logic [11:0] PC_RESET       = 12'h000,
    parameter int          MEM_ADDR_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      run,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]               mem_wdata,
    output logic                      mem_we,
    input  logic [15:0]               mem_rdata,
    output logic [3:0]                alu_op,
    output logic [15:0]               alu_a,
    output logic [15:0]               alu_b,
    input  logic [15:0]               alu_result,
    output logic [11:0]               pc,
    output logic [15:0]               ac,
    output logic [15:0]               ir,
    output logic                      halted,
    output logic                      retire,
    output logic                      illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_OWAIT,
        S_EXEC,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_JUMP  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t      state, state_next;
    logic [15:0] mbr;
    logic [11:0] pc_next;
    logic [15:0] ir_next, mbr_next, ac_next;
    logic        halted_next;
    logic [3:0]  opcode;
    logic        is_mem_read;
    logic        is_undef;
    logic        skip_true;

    assign opcode      = ir[15:12];
    assign is_mem_read = (opcode == OP_LOAD) || (opcode == OP_ADD) || (opcode == OP_SUB)
                      || (opcode == OP_AND)  || (opcode == OP_OR);
    assign is_undef    = (opcode >= 4'hA) && (opcode <= 4'hE);

    // AC is compared as a signed value; condition 11 never skips.
    always_comb begin
        skip_true = 1'b0;
        case (ir[11:10])
            2'b00:   skip_true = ac[15];
            2'b01:   skip_true = (ac == 16'h0000);
            2'b10:   skip_true = !ac[15] && (ac != 16'h0000);
            default: skip_true = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_FETCH;
            pc     <= PC_RESET;
            ir     <= 16'h0000;
            mbr    <= 16'h0000;
            ac     <= 16'h0000;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            ir     <= ir_next;
            mbr    <= mbr_next;
            ac     <= ac_next;
            halted <= halted_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        ir_next     = ir;
        mbr_next    = mbr;
        ac_next     = ac;
        halted_next = halted;
        mem_addr    = MEM_ADDR_WIDTH'(pc);
        mem_we      = 1'b0;
        alu_op      = 4'b0000;
        retire      = 1'b0;
        illegal     = 1'b0;

        case (state)
            S_FETCH: begin
                if (run) state_next = S_FWAIT;
            end
            S_FWAIT: begin
                ir_next    = mem_rdata;
                pc_next    = pc + 12'd1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                state_next = S_FETCH;
                retire     = !is_mem_read;
                illegal    = is_undef;
                if (is_mem_read) begin
                    mem_addr   = MEM_ADDR_WIDTH'(ir[11:0]);
                    state_next = S_OWAIT;
                end else begin
                    case (opcode)
                        OP_JUMP:  pc_next = ir[11:0];
                        OP_SKIP:  if (skip_true) pc_next = pc + 12'd1;
                        OP_STORE: begin
                            mem_addr = MEM_ADDR_WIDTH'(ir[11:0]);
                            mem_we   = 1'b1;
                        end
                        OP_HALT: begin
                            halted_next = 1'b1;
                            state_next  = S_HALTED;
                        end
                        default: ;
                    endcase
                end
            end
            S_OWAIT: begin
                mbr_next   = mem_rdata;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                retire     = 1'b1;
                state_next = S_FETCH;
                case (opcode)
                    OP_SUB:  alu_op = 4'b0001;
                    OP_AND:  alu_op = 4'b1000;
                    OP_OR:   alu_op = 4'b1001;
                    default: alu_op = 4'b0000;
                endcase
                ac_next = (opcode == OP_LOAD) ? mbr : alu_result;
            end
            S_HALTED: state_next = S_HALTED;
            default:  state_next = S_FETCH;
        endcase
    end

    assign mem_wdata = ac;
    assign alu_a     = ac;
    assign alu_b     = mbr;

    // OP_NOP is covered by the default decode path; named for readability only.
    logic unused_nop;
    assign unused_nop = (opcode == OP_NOP);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer with a registered-read
// memory model and a behavioural ALU.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata = 16'h0000;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic [11:0] pc;
    logic [15:0] ac;
    logic [15:0] ir;
    logic        halted;
    logic        retire;
    logic        illegal;

    logic [15:0] mem [0:4095];
    int errors = 0;
    int checks = 0;
    int retire_cnt = 0;
    int we_cnt = 0;
    int illegal_cnt = 0;

    control_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .pc         (pc),
        .ac         (ac),
        .ir         (ir),
        .halted     (halted),
        .retire     (retire),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    // Memory returns read data one cycle after the address is presented.
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[11:0]];
    end

    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b1000: alu_result = alu_a & alu_b;
            4'b1001: alu_result = alu_a | alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    always @(negedge clock) begin
        if (retire)  retire_cnt  = retire_cnt + 1;
        if (mem_we)  we_cnt      = we_cnt + 1;
        if (illegal) illegal_cnt = illegal_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
    endtask

    task automatic setMem(input int addr, input logic [15:0] data);
        mem[addr] <= data;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Pulse reset for one edge and release it just after a rising edge.
    task automatic applyStimulus(input logic run_val);
        reset_n = 1'b0;
        run     = run_val;
        @(posedge clock);
        #1;
        reset_n     = 1'b1;
        retire_cnt  = 0;
        we_cnt      = 0;
        illegal_cnt = 0;
    endtask

    task automatic runSkip(input string tag, input logic [15:0] val,
                           input logic [15:0] instr, input logic [15:0] exp_pc);
        clearMem();
        setMem(0, 16'h1020);
        setMem(32'h20, val);
        setMem(1, instr);
        applyStimulus(1'b1);
        step(8);
        checkOutput(tag, {4'h0, pc}, exp_pc);
        checkOutput({tag, "_retires"}, 16'(retire_cnt), 16'd2);
    endtask

    initial begin
        // Test-plan program: LOAD 4, ADD 5, HALT
        clearMem();
        setMem(0, 16'h1004);
        setMem(4, 16'h0007);
        setMem(1, 16'h3005);
        setMem(5, 16'h0003);
        setMem(2, 16'hF000);
        applyStimulus(1'b1);
        checkOutput("rst_pc", {4'h0, pc}, 16'h0000);
        checkOutput("rst_ac", ac, 16'h0000);
        checkOutput("rst_ir", ir, 16'h0000);
        checkOutput("rst_halted", 16'(halted), 16'd0);
        checkOutput("rst_retire", 16'(retire), 16'd0);
        checkOutput("rst_illegal", 16'(illegal), 16'd0);
        checkOutput("rst_we", 16'(mem_we), 16'd0);
        checkOutput("rst_addr", mem_addr, 16'h0000);
        step(5);
        checkOutput("prog_ac_load", ac, 16'h0007);
        checkOutput("prog_retire1", 16'(retire_cnt), 16'd1);
        step(5);
        checkOutput("prog_ac_add", ac, 16'h000A);
        step(3);
        checkOutput("prog_halted", 16'(halted), 16'd1);
        checkOutput("prog_pc", {4'h0, pc}, 16'h0003);
        checkOutput("prog_retires", 16'(retire_cnt), 16'd3);
        step(4);
        checkOutput("halt_pc_hold", {4'h0, pc}, 16'h0003);
        checkOutput("halt_we", 16'(mem_we), 16'd0);
        checkOutput("halt_addr", mem_addr, 16'h0003);
        checkOutput("halt_sticky", 16'(halted), 16'd1);
        checkOutput("halt_retires", 16'(retire_cnt), 16'd3);

        // STORE of BEEF to 0x010
        clearMem();
        setMem(0, 16'h1020);
        setMem(32'h20, 16'hBEEF);
        setMem(1, 16'h2010);
        setMem(2, 16'hF000);
        applyStimulus(1'b1);
        step(5);
        checkOutput("st_ac", ac, 16'hBEEF);
        step(2);
        checkOutput("st_we", 16'(mem_we), 16'd1);
        checkOutput("st_addr", mem_addr, 16'h0010);
        checkOutput("st_wdata", mem_wdata, 16'hBEEF);
        checkOutput("st_retire", 16'(retire), 16'd1);
        step(1);
        checkOutput("st_we_off", 16'(mem_we), 16'd0);
        checkOutput("st_we_cnt", 16'(we_cnt), 16'd1);
        checkOutput("st_mem", mem[16], 16'hBEEF);
        checkOutput("st_pc", {4'h0, pc}, 16'h0002);
        checkOutput("st_ir", ir, 16'h2010);

        // Reset asserted during STORE DECODE
        clearMem();
        setMem(0, 16'h1020);
        setMem(32'h20, 16'hBEEF);
        setMem(1, 16'h2030);
        applyStimulus(1'b1);
        step(7);
        checkOutput("rs_we_before", 16'(mem_we), 16'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rs_we_drop", 16'(mem_we), 16'd0);
        checkOutput("rs_pc", {4'h0, pc}, 16'h0000);
        checkOutput("rs_ac", ac, 16'h0000);
        checkOutput("rs_ir", ir, 16'h0000);
        step(1);
        checkOutput("rs_no_write", mem[48], 16'h0000);

        // run=0 after reset: no access, PC holds
        applyStimulus(1'b0);
        step(6);
        checkOutput("idle_pc", {4'h0, pc}, 16'h0000);
        checkOutput("idle_we", 16'(we_cnt), 16'd0);
        checkOutput("idle_ir", ir, 16'h0000);

        // SKIPCOND variants
        runSkip("skip_neg", 16'h8000, 16'h8000, 16'h0003);
        runSkip("skip_zero", 16'h0000, 16'h8400, 16'h0003);
        runSkip("skip_pos", 16'h0001, 16'h8800, 16'h0003);
        runSkip("noskip_neg", 16'h0001, 16'h8000, 16'h0002);
        runSkip("noskip_never", 16'h8000, 16'h8C00, 16'h0002);
        runSkip("noskip_signed", 16'h8000, 16'h8800, 16'h0002);

        // PC wrap through NOP at FFF
        clearMem();
        setMem(0, 16'h7FFF);
        setMem(32'hFFF, 16'h0000);
        applyStimulus(1'b1);
        step(3);
        checkOutput("wrap_jump", {4'h0, pc}, 16'h0FFF);
        step(3);
        checkOutput("wrap_pc", {4'h0, pc}, 16'h0000);

        clearMem();
        setMem(0, 16'h7ABC);
        applyStimulus(1'b1);
        step(3);
        checkOutput("jump_pc", {4'h0, pc}, 16'h0ABC);

        // ALU ops including ADD overflow
        clearMem();
        setMem(0, 16'h1020);
        setMem(32'h20, 16'hFFFF);
        setMem(1, 16'h3021);
        setMem(32'h21, 16'h0001);
        setMem(2, 16'h1022);
        setMem(32'h22, 16'h00F0);
        setMem(3, 16'h3023);
        setMem(32'h23, 16'h000F);
        setMem(4, 16'h4024);
        setMem(32'h24, 16'h0100);
        setMem(5, 16'h5025);
        setMem(32'h25, 16'h0F0F);
        setMem(6, 16'h6026);
        setMem(32'h26, 16'h3000);
        applyStimulus(1'b1);
        step(10);
        checkOutput("add_ovf", ac, 16'h0000);
        step(10);
        checkOutput("add", ac, 16'h00FF);
        step(5);
        checkOutput("sub", ac, 16'hFFFF);
        step(5);
        checkOutput("and", ac, 16'h0F0F);
        step(5);
        checkOutput("or", ac, 16'h3F0F);

        // Undefined opcode
        clearMem();
        setMem(0, 16'hA123);
        applyStimulus(1'b1);
        step(2);
        checkOutput("ill_pulse", 16'(illegal), 16'd1);
        checkOutput("ill_retire", 16'(retire), 16'd1);
        checkOutput("ill_ir", ir, 16'hA123);
        step(1);
        checkOutput("ill_clear", 16'(illegal), 16'd0);
        checkOutput("ill_pc", {4'h0, pc}, 16'h0001);
        checkOutput("ill_ac", ac, 16'h0000);
        checkOutput("ill_we", 16'(we_cnt), 16'd0);
        step(3);
        checkOutput("ill_next_pc", {4'h0, pc}, 16'h0002);
        checkOutput("ill_cnt", 16'(illegal_cnt), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Fetch/decode/execute sequencer for the 16-bit accumulator machine.
- Owns the architectural registers PC, IR, MBR and AC.
- Drives main-memory address, write data and write enable.
- Sits directly upstream of the ALU: supplies its opcode and operands, and captures its result into AC.

Parameters:
PC_RESET, 12'h000, PC value loaded on reset
MEM_ADDR_WIDTH, 16, width of mem_addr; the 12-bit operand address is zero-extended to this width

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
run  input  1  when 0, sequencer holds in FETCH and issues no access
mem_addr  output  MEM_ADDR_WIDTH  memory address
mem_wdata  output  16  memory write data (always AC)
mem_we  output  1  memory write enable
mem_rdata  input  16  memory read data, valid the cycle after the address is presented with mem_we=0
alu_op  output  4  ALU operation code
alu_a  output  16  ALU operand 1 (AC)
alu_b  output  16  ALU operand 2 (MBR)
alu_result  input  16  combinational ALU result
pc  output  12  program counter
ac  output  16  accumulator
ir  output  16  instruction register
halted  output  1  high once HALT has executed
retire  output  1  one-cycle pulse as each instruction completes
illegal  output  1  one-cycle pulse on decode of an undefined opcode

Behaviour:
- Instruction format: [15:12] opcode, [11:0] address/operand.
- Opcodes:
  - 0 NOP
  - 1 LOAD
  - 2 STORE
  - 3 ADD
  - 4 SUB
  - 5 AND
  - 6 OR
  - 7 JUMP
  - 8 SKIPCOND
  - F HALT
  - A-E are undefined: executed as NOP and pulse illegal in DECODE.
- Reset (asynchronous, reset_n=0):
  - pc=PC_RESET; ir, mbr, ac = 0.
  - halted=0; retire=0; illegal=0.
  - State = FETCH.
  - mem_we=0 immediately; mem_we and mem_addr are decoded combinationally from state.
  - Reset mid-instruction abandons that instruction; no partial write.
- States and transitions:
  - FETCH:
    - run=1: mem_addr=pc, mem_we=0, go to FWAIT.
    - run=0: stay in FETCH, mem_we=0.
  - FWAIT: ir<=mem_rdata; pc<=pc+1, 12-bit wrap (FFF -> 000); go to DECODE.
  - DECODE:
    - NOP/undefined: go to FETCH.
    - JUMP: pc<=ir[11:0]; go to FETCH.
    - SKIPCOND, condition in ir[11:10], AC treated as signed:
      - 00: AC<0
      - 01: AC==0
      - 10: AC>0
      - 11: never
      - If the condition is true, pc<=pc+1 (wrapping). Go to FETCH.
    - STORE: mem_addr=ir[11:0], mem_wdata=ac, mem_we=1 for exactly this cycle; go to FETCH.
    - LOAD/ADD/SUB/AND/OR: mem_addr=ir[11:0], mem_we=0; go to OWAIT.
    - HALT: halted<=1; go to HALTED.
  - OWAIT: mbr<=mem_rdata; go to EXEC.
  - EXEC:
    - alu_op: ADD=0000, SUB=0001, AND=1000, OR=1001.
    - LOAD: ac<=mbr. Otherwise ac<=alu_result (16-bit, overflow discarded).
    - Go to FETCH.
  - HALTED: terminal. No memory access; only reset leaves this state.
- alu_op outside EXEC: 0000. alu_a=ac and alu_b=mbr at all times.
- retire: pulses in the final cycle of each instruction (DECODE for 3-cycle ops, EXEC for memory-read ops, DECODE for HALT).
- Latency:
  - NOP, JUMP, SKIPCOND, STORE, HALT: 3 cycles.
  - LOAD, ADD, SUB, AND, OR: 5 cycles.
- run is sampled only in FETCH; deasserting run mid-instruction does not stall that instruction.
- mem_addr upper bits are always zero. Outside FETCH/DECODE/accessing states, mem_addr holds pc.

Test Plan:
- Reset with mem[0]=1004, mem[4]=0007, mem[1]=3005, mem[5]=0003, mem[2]=F000, run=1 -> ac=7 after 5 cycles, ac=000A after 10, halted=1 at cycle 13, pc=003; 3 retire pulses.
- STORE: ac=BEEF, instruction 2010 -> mem_we high exactly one cycle with mem_addr=0010, mem_wdata=BEEF; instruction takes 3 cycles.
- SKIPCOND:
  - ac=8000 with 8000 -> pc advances by 2.
  - ac=0000 with 8400 -> pc advances by 2.
  - ac=0001 with 8800 -> pc advances by 2.
  - ac=0001 with 8000 -> pc advances by 1.
  - 8C00 -> never skips.
- Wrap: pc=FFF, instruction at FFF is NOP -> pc=000 next. JUMP 7ABC -> pc=ABC. ADD overflow FFFF+0001 -> ac=0000.
- Undefined opcode A123 -> illegal pulses one cycle in DECODE, no state change besides pc+1, 3 cycles.
- reset_n low during STORE DECODE -> mem_we drops immediately and all registers are 0. With run=0 after reset -> mem_we stays 0 and pc holds.
